// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared direction codes and paddle FSM state type
package pong_pkg;

    localparam logic [1:0] DIR_NONE  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } paddle_state_t;

endpackage

// File: rtl/paddle_axis.sv
// rtl/paddle_axis.sv - one paddle: direction FSM, step ramp, playfield clamp, output regs
module paddle_axis
    import pong_pkg::*;
#(
    parameter int X_BITS      = 10,
    parameter int SCREEN_W    = 640,
    parameter int DEFAULT_X   = 260,
    parameter int DEFAULT_W   = 150,
    parameter int STEP_MIN    = 1,
    parameter int STEP_MAX    = 6,
    parameter int ACCEL_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_tick,
    input  logic [1:0]        dir,
    input  logic [X_BITS-1:0] width,
    input  logic              game_end,
    output logic [X_BITS-1:0] x1,
    output logic [X_BITS-1:0] x2,
    output logic [1:0]        at_edge
);
    localparam int HC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam int ST_W = $clog2(STEP_MAX + 1);
    localparam int AW   = X_BITS + 1;

    localparam logic [AW-1:0]     SCREEN    = AW'(SCREEN_W);
    localparam logic [ST_W-1:0]   STEP_LO   = ST_W'(STEP_MIN);
    localparam logic [ST_W-1:0]   STEP_HI   = ST_W'(STEP_MAX);
    localparam logic [HC_W:0]     HOLD_LAST = (HC_W + 1)'(ACCEL_TICKS - 1);
    localparam logic [X_BITS-1:0] X1_RST    = X_BITS'(DEFAULT_X);
    localparam logic [X_BITS-1:0] X2_RST    = X_BITS'(DEFAULT_X + DEFAULT_W);

    paddle_state_t     state_q, state_d, tgt;
    logic [X_BITS-1:0] pos_q, pos_d;
    logic [ST_W-1:0]   step_q, step_d, step_use;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [HC_W:0]     hold_inc;
    logic [AW-1:0]     wc, rlim, pos_ext, step_ext, pos_mv, x2_sum;
    logic              active;
    logic              unused_bits;

    // Arithmetic is one bit wider than coordinates so left/right limits never wrap.
    always_comb begin
        active   = move_tick && !game_end;
        wc       = ({1'b0, width} > SCREEN) ? SCREEN : {1'b0, width};
        rlim     = SCREEN - wc;
        pos_ext  = {1'b0, pos_q};
        x2_sum   = pos_ext + wc;
        hold_inc = {1'b0, hold_q} + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        step_d   = step_q;
        hold_d   = hold_q;
        step_use = step_q;
        step_ext = '0;
        pos_mv   = pos_ext;
        case (dir)
            DIR_LEFT:  tgt = MOVE_L;
            DIR_RIGHT: tgt = MOVE_R;
            default:   tgt = IDLE;
        endcase

        if (active) begin
            state_d = tgt;
            if (tgt == IDLE || tgt != state_q) begin
                step_use = STEP_LO;
                step_d   = STEP_LO;
                hold_d   = '0;
            end else if (hold_inc >= HOLD_LAST) begin
                hold_d = '0;
                step_d = (step_q >= STEP_HI) ? STEP_HI : step_q + 1'b1;
            end else begin
                hold_d = hold_inc[HC_W-1:0];
            end

            step_ext = AW'(step_use);
            if (tgt == MOVE_L) begin
                pos_mv = (pos_ext >= step_ext) ? pos_ext - step_ext : '0;
            end else if (tgt == MOVE_R) begin
                pos_mv = (pos_ext + step_ext <= rlim) ? pos_ext + step_ext : rlim;
            end
            // A width change can leave the paddle past the right limit in any state.
            if (pos_mv > rlim) begin
                pos_mv = rlim;
            end
            pos_d = pos_mv[X_BITS-1:0];
        end
    end

    assign unused_bits = ^{pos_mv[X_BITS], x2_sum[X_BITS]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= X1_RST;
            step_q  <= STEP_LO;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1      <= X1_RST;
            x2      <= X2_RST;
            at_edge <= '0;
        end else if (!game_end) begin
            x1      <= pos_q;
            x2      <= x2_sum[X_BITS-1:0];
            at_edge <= {pos_ext == rlim, pos_q == '0};
        end
    end

endmodule

// File: rtl/paddle_array_ctrl.sv
// rtl/paddle_array_ctrl.sv - array of independent paddles sharing tick, freeze and reset
module paddle_array_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES = 2,
    parameter int X_BITS      = 10,
    parameter int SCREEN_W    = 640,
    parameter int DEFAULT_X   = 260,
    parameter int DEFAULT_W   = 150,
    parameter int STEP_MIN    = 1,
    parameter int STEP_MAX    = 6,
    parameter int ACCEL_TICKS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          move_tick,
    input  logic [2*NUM_PADDLES-1:0]      dir,
    input  logic [X_BITS*NUM_PADDLES-1:0] width,
    input  logic                          game_end,
    output logic [X_BITS*NUM_PADDLES-1:0] x1,
    output logic [X_BITS*NUM_PADDLES-1:0] x2,
    output logic [2*NUM_PADDLES-1:0]      at_edge
);

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_paddle
        paddle_axis #(
            .X_BITS      (X_BITS),
            .SCREEN_W    (SCREEN_W),
            .DEFAULT_X   (DEFAULT_X),
            .DEFAULT_W   (DEFAULT_W),
            .STEP_MIN    (STEP_MIN),
            .STEP_MAX    (STEP_MAX),
            .ACCEL_TICKS (ACCEL_TICKS)
        ) u_axis (
            .clk       (clk),
            .reset     (reset),
            .move_tick (move_tick),
            .dir       (dir[i*2 +: 2]),
            .width     (width[i*X_BITS +: X_BITS]),
            .game_end  (game_end),
            .x1        (x1[i*X_BITS +: X_BITS]),
            .x2        (x2[i*X_BITS +: X_BITS]),
            .at_edge   (at_edge[i*2 +: 2])
        );
    end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// tb/tb_paddle_array_ctrl.sv - directed self-checking bench for paddle_array_ctrl
module tb_paddle_array_ctrl;
    localparam int NP = 2;
    localparam int XB = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             move_tick;
    logic [2*NP-1:0]  dir;
    logic [XB*NP-1:0] width;
    logic             game_end;
    logic [XB*NP-1:0] x1;
    logic [XB*NP-1:0] x2;
    logic [2*NP-1:0]  at_edge;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    paddle_array_ctrl #(
        .NUM_PADDLES (NP),
        .X_BITS      (XB),
        .SCREEN_W    (640),
        .DEFAULT_X   (260),
        .DEFAULT_W   (150),
        .STEP_MIN    (1),
        .STEP_MAX    (6),
        .ACCEL_TICKS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .move_tick (move_tick),
        .dir       (dir),
        .width     (width),
        .game_end  (game_end),
        .x1        (x1),
        .x2        (x2),
        .at_edge   (at_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_paddle(input string tag, input int p, input int ex1, input int ex2, input int eedge);
        check({tag, ".x1"}, 32'(x1[p*XB +: XB]), 32'(ex1));
        check({tag, ".x2"}, 32'(x2[p*XB +: XB]), 32'(ex2));
        check({tag, ".edge"}, 32'(at_edge[p*2 +: 2]), 32'(eedge));
    endtask

    task automatic pulse();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    // n back-to-back ticks, then one idle cycle so the outputs catch up.
    task automatic ticks(input int n);
        repeat (n) pulse();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        move_tick = 1'b0;
        dir       = '0;
        width     = {10'd150, 10'd150};
        game_end  = 1'b0;

        @(negedge clk);
        check_paddle("rst_p0", 0, 260, 410, 0);
        check_paddle("rst_p1", 1, 260, 410, 0);
        reset = 1'b1;
        @(negedge clk);
        check_paddle("post_rst_p0", 0, 260, 410, 0);
        ticks(100);
        check_paddle("idle100_p0", 0, 260, 410, 0);
        check_paddle("idle100_p1", 1, 260, 410, 0);

        dir[1:0] = 2'd2;
        for (int k = 1; k <= 8; k++) begin
            ticks(1);
            check("ramp1_x1", 32'(x1[9:0]), 32'(260 + k));
        end
        ticks(1);
        check("ramp_t9", 32'(x1[9:0]), 32'd270);
        ticks(6);
        check("ramp_t15", 32'(x1[9:0]), 32'd282);
        ticks(1);
        check("ramp_step3", 32'(x1[9:0]), 32'd285);
        check_paddle("p1_untouched", 1, 260, 410, 0);

        dir[1:0]   = 2'd0;
        width[9:0] = 10'd617;
        ticks(1);
        check_paddle("shrink_clamp", 0, 23, 640, 2);

        width[9:0] = 10'd150;
        dir[1:0]   = 2'd1;
        ticks(14);
        check("left_at3", 32'(x1[9:0]), 32'd3);
        ticks(1);
        check("left_to1", 32'(x1[9:0]), 32'd1);
        ticks(1);
        check_paddle("left_to0", 0, 0, 150, 1);
        ticks(2);
        check_paddle("left_hold0", 0, 0, 150, 1);

        dir[1:0] = 2'd2;
        ticks(120);
        check_paddle("right_clamp", 0, 490, 640, 2);
        width[9:0] = 10'd200;
        @(negedge clk);
        check("grow_x2_early", 32'(x2[9:0]), 32'd690);
        check("grow_x1_early", 32'(x1[9:0]), 32'd490);
        ticks(1);
        check_paddle("grow_clamp", 0, 440, 640, 2);

        dir[1:0] = 2'd0;
        dir[3:2] = 2'd2;
        ticks(22);
        check("p1_ramp22", 32'(x1[19:10]), 32'd303);
        game_end = 1'b1;
        ticks(20);
        check_paddle("frozen_p1", 1, 303, 453, 0);
        check_paddle("frozen_p0", 0, 440, 640, 2);
        game_end = 1'b0;
        ticks(1);
        check("resume_step4", 32'(x1[19:10]), 32'd307);
        dir[3:2] = 2'd1;
        ticks(1);
        check("reverse_l1", 32'(x1[19:10]), 32'd306);
        ticks(1);
        check("reverse_l2", 32'(x1[19:10]), 32'd305);

        dir[3:2] = 2'd2;
        ticks(10);
        check("p1_right10", 32'(x1[19:10]), 32'd317);
        dir[3:2] = 2'd3;
        ticks(1);
        check("dir3_hold", 32'(x1[19:10]), 32'd317);
        dir[3:2] = 2'd2;
        ticks(1);
        check("dir3_step_reset", 32'(x1[19:10]), 32'd318);

        move_tick = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_paddle("async_rst_p1", 1, 260, 410, 0);
        check_paddle("async_rst_p0", 0, 260, 410, 0);
        move_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/paddle_array_ctrl.md
# paddle_array_ctrl

Parametrised controller for NUM_PADDLES horizontal paddles. It moves each paddle on a frame-rate update strobe and ramps the step size while a direction is held. Each paddle is clamped to the playfield given its live width, and all paddles freeze while the game is over. It sits between the debounced player-input decoder and the ball/collision and pixel-render logic, and supplies registered paddle edge coordinates to both.

## Interface
- NUM_PADDLES, 2, number of independent paddles (1–8)
- X_BITS, 10, coordinate and width bit width
- SCREEN_W, 640, playfield width in pixels; valid x is 0..SCREEN_W
- DEFAULT_X, 260, left edge after reset
- DEFAULT_W, 150, width assumed for x2 at reset
- STEP_MIN, 1, initial step in pixels per tick
- STEP_MAX, 6, step ceiling
- ACCEL_TICKS, 8, held ticks per step increment (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- move_tick  in  1  single-cycle update strobe (one per frame)
- dir  in  2*NUM_PADDLES  per-paddle direction; 2'd0 none, 2'd1 left, 2'd2 right, 2'd3 treated as none
- width  in  X_BITS*NUM_PADDLES  per-paddle width; values above SCREEN_W are treated as SCREEN_W
- game_end  in  1  freeze all paddle state and outputs while high
- x1  out  X_BITS*NUM_PADDLES  registered left edge per paddle
- x2  out  X_BITS*NUM_PADDLES  registered right edge (x1 + width) per paddle
- at_edge  out  2*NUM_PADDLES  per paddle: bit0 = at left limit, bit1 = at right limit

## Operation
- Paddle i uses slice [i*2 +: 2] of dir and at_edge, and slice [i*X_BITS +: X_BITS] of width, x1 and x2.
- Per-paddle FSM has three states: IDLE, MOVE_L and MOVE_R. It advances only on cycles where move_tick=1 and game_end=0.
  - dir=left gives MOVE_L; dir=right gives MOVE_R; none or 3 gives IDLE.
  - Entering MOVE_L or MOVE_R from any other state sets step=STEP_MIN and hold_cnt=0, and applies the move in that same tick.
  - Staying in the same MOVE state increments hold_cnt. When hold_cnt reaches ACCEL_TICKS-1, it wraps to 0 and step becomes min(step+1, STEP_MAX). The move uses the pre-increment step.
  - IDLE resets step=STEP_MIN and hold_cnt=0; position holds.
- Limits: wc = min(width, SCREEN_W) and rlim = SCREEN_W − wc. All arithmetic is done in X_BITS+1 bits with no wrap.
  - Left: pos = (pos ≥ step) ? pos − step : 0.
  - Right: pos = (pos + step ≤ rlim) ? pos + step : rlim.
- Width shrink or grow: on every active tick, including IDLE, if pos > rlim then pos = rlim.
- Outputs: x1 = pos, x2 = pos + wc, at_edge[0] = (pos==0), at_edge[1] = (pos==rlim). They are registered from the updated state.
- game_end=1: pos, step, hold_cnt, FSM state and all outputs hold, regardless of move_tick. Normal operation resumes on the first tick after game_end falls; the FSM keeps its pre-freeze state, so held acceleration continues.
- Reset (any time, including mid-move): pos=DEFAULT_X, step=STEP_MIN, hold_cnt=0, state=IDLE, x1=DEFAULT_X, x2=DEFAULT_X+DEFAULT_W, at_edge=0.

## Timing
- Internal state updates on the rising edge of the move_tick cycle. x1, x2 and at_edge reflect that update one clk later, so output latency is 2 cycles from the move_tick assertion.
- Outputs are also refreshed every non-frozen cycle from pos and the current width. A width change therefore shows on x2 within 2 cycles even with no tick; the pos clamp waits for a tick.
- dir and width are sampled only on the move_tick cycle for movement. They need no handshake, because inputs are synchronous to clk.
- Back-to-back move_tick on consecutive cycles is legal; each tick is one update.

## Structure
- Shared package pong_pkg holds:
  - DIR_NONE, DIR_LEFT and DIR_RIGHT localparams;
  - the paddle_state_t enum (IDLE, MOVE_L, MOVE_R).
- Sub-module paddle_axis implements one paddle (FSM, accel counter, clamp, output regs). paddle_array_ctrl instantiates it NUM_PADDLES times via a generate loop and only slices buses.
- hold_cnt width is $clog2(ACCEL_TICKS) (minimum 1); step width is $clog2(STEP_MAX+1).

## Test plan
- Reset then release, no input: x1=260 and x2=410 for all paddles, at_edge=0; 100 ticks with dir=0 give no change.
- Paddle0 right held, defaults: positions after ticks 1..8 are 261..268; tick 9 gives 270 (step 2); after 8 more ticks the step is 3. Paddle1 is unaffected.
- Paddle0 left held from x1=3 with step 2: 1, then 0; at_edge[0]=1 and x1 stays 0 on further ticks.
- Right held with width=150 until x1=490: clamps at 490, x2=640, at_edge[1]=1. Width then set to 200: x2=690 for one tick, then x1=440, x2=640.
- Mid-ramp (step 4) assert game_end for 20 ticks: outputs unchanged. Deassert with dir still right: the next tick moves +4. Reverse to left: step returns to 1.
- dir=3 during a move: the paddle holds and the step resets. reset asserted mid-move with no clk edge: outputs go to 260/410 immediately.
